vga_scan_generator: RTL and testbench

VGA_SCAN_GENERATOR -- requirements
Module: vga_scan_generator

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_scan_generator.sv | 83 ++++++++
 tb/tb_vga_scan_generator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the coordinate type used by the scan generator
// and the colour mapper.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping position counter plus sync / visible decode taken
// straight from the count register.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   en,
  output coord_t count,
  output logic   sync_n,
  output logic   visible,
  output logic   wrap
);

  localparam int     TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int     SYNC_START = VISIBLE + FRONT;
  localparam int     SYNC_END   = VISIBLE + FRONT + SYNC;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);

  if (TOTAL > (1 << COORD_W)) begin : g_total_check
    $error("vga_axis_counter: TOTAL=%0d does not fit a %0d-bit counter", TOTAL, COORD_W);
  end

  coord_t r_count;
  logic   w_at_last;

  assign w_at_last = (r_count == LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_at_last ? '0 : r_count + coord_t'(1);
    end
  end

  // Decodes use the registered count so they line up with count itself.
  assign count   = r_count;
  assign wrap    = en && w_at_last;
  assign sync_n  = !((int'(r_count) >= SYNC_START) && (int'(r_count) < SYNC_END));
  assign visible = (int'(r_count) < VISIBLE);

endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster scan timing: pixel strobe at Clk/2, horizontal and vertical
// position counters, active-low syncs, visible-area flag and frame strobe.
module vga_scan_generator
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_ce,
  output logic   hs,
  output logic   vs,
  output logic   display_on,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_start
);

  logic   r_div;
  coord_t w_hc;
  coord_t w_vc;
  logic   w_h_wrap;
  logic   w_h_vis;
  logic   w_v_vis;
  logic   w_h_sync_n;
  logic   w_v_sync_n;
  logic   w_unused_v_wrap;

  // Reset clears div so the first post-reset cycle carries the strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (r_div),
    .count   (w_hc),
    .sync_n  (w_h_sync_n),
    .visible (w_h_vis),
    .wrap    (w_h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (w_h_wrap),
    .count   (w_vc),
    .sync_n  (w_v_sync_n),
    .visible (w_v_vis),
    .wrap    (w_unused_v_wrap)
  );

  assign pixel_ce    = r_div;
  assign DrawX       = w_hc;
  assign DrawY       = w_vc;
  assign hs          = w_h_sync_n;
  assign vs          = w_v_sync_n;
  assign display_on  = w_h_vis && w_v_vis;
  assign frame_start = r_div && (w_hc == '0) && (w_vc == '0);

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: a default-timing instance and a small-timing
// instance compared every cycle against a closed-form cycle-count model.
module tb_vga_scan_generator;

  // Small instance geometry: 30 x 19 total, 16 x 10 visible.
  localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 4;
  localparam int S_VV = 10, S_VF = 2, S_VS = 3, S_VB = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;

  logic       d_ce, d_hs, d_vs, d_don, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_ce, s_hs, s_vs, s_don, s_fs;
  logic [9:0] s_x, s_y;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_n      = 0;
  bit m_valid  = 1'b0;

  always #10 Clk = ~Clk;

  vga_scan_generator dut_d (
    .Clk         (Clk),
    .Reset       (Reset),
    .pixel_ce    (d_ce),
    .hs          (d_hs),
    .vs          (d_vs),
    .display_on  (d_don),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .frame_start (d_fs)
  );

  vga_scan_generator #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) dut_s (
    .Clk         (Clk),
    .Reset       (Reset),
    .pixel_ce    (s_ce),
    .hs          (s_hs),
    .vs          (s_vs),
    .display_on  (s_don),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .frame_start (s_fs)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Closed-form reference: n counts Clk edges since the last reset edge.
  // Pixel index p = n/2, strobe on odd n, raster position from p.
  function automatic logic [24:0] ref_out(input int n,
      input int hv, input int hf, input int hsw, input int hb,
      input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, p, hc, vc;
    logic ce, hs_e, vs_e, don_e, fs_e;
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    p     = n / 2;
    hc    = p % ht;
    vc    = (p / ht) % vt;
    ce    = (n % 2) == 1;
    hs_e  = !((hc >= hv + hf) && (hc < hv + hf + hsw));
    vs_e  = !((vc >= vv + vf) && (vc < vv + vf + vsw));
    don_e = (hc < hv) && (vc < vv);
    fs_e  = ce && ((p % (ht * vt)) == 0);
    return {ce, hs_e, vs_e, don_e, fs_e, 10'(hc), 10'(vc)};
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_n     <= 0;
      m_valid <= 1'b1;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      check_eq("d_cycle", {d_ce, d_hs, d_vs, d_don, d_fs, d_x, d_y},
               ref_out(m_n, 640, 16, 96, 48, 480, 10, 2, 33));
      check_eq("s_cycle", {s_ce, s_hs, s_vs, s_don, s_fs, s_x, s_y},
               ref_out(m_n, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int k);
    Reset = 1'b1;
    repeat (k) step();
    Reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int   hs_fall1, hs_fall2, hs_rise1, don_fall1;
    logic p_hs, p_don;
    int   last_fs, fs_seen, vs_run, vs_runs, don_cnt, max_x, max_y;

    // Phase A: default timing, reset behaviour and first two lines.
    do_reset(3);
    check_eq("rst_ce", d_ce, 0);
    check_eq("rst_xy", {d_x, d_y}, 0);
    check_eq("rst_syncs", {d_hs, d_vs, d_don, d_fs}, 4'b1110);
    hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1; don_fall1 = -1;
    p_hs = 1'b1; p_don = 1'b1;
    for (int c = 1; c <= 3300; c++) begin
      step();
      if (c == 1) begin
        check_eq("rel_ce_fs", {d_ce, d_fs}, 2'b11);
        check_eq("rel_xy", {d_x, d_y}, 0);
        check_eq("rel_hs_vs_don", {d_hs, d_vs, d_don}, 3'b111);
      end
      if (c == 3)    check_eq("rel_x_c3", d_x, 1);
      if (c == 1599) check_eq("line_end_xy", {d_x, d_y}, {10'd799, 10'd0});
      if (c == 1600) check_eq("line_wrap_xy", {d_x, d_y}, {10'd0, 10'd1});
      if (p_hs && !d_hs) begin
        if (hs_fall1 < 0) hs_fall1 = c;
        else if (hs_fall2 < 0) hs_fall2 = c;
      end
      if (!p_hs && d_hs && hs_rise1 < 0) hs_rise1 = c;
      if (p_don && !d_don && don_fall1 < 0) don_fall1 = c;
      p_hs = d_hs;
      p_don = d_don;
    end
    check_eq("hs_fall_clk", hs_fall1, 1312);
    check_eq("hs_rise_clk", hs_rise1, 1504);
    check_eq("don_fall_clk", don_fall1, 1280);
    check_eq("line_period", hs_fall2 - hs_fall1, 1600);

    // Phase B: small timing, three full frames.
    do_reset(2);
    last_fs = -1; fs_seen = 0; vs_run = 0; vs_runs = 0; don_cnt = 0; max_x = 0; max_y = 0;
    for (int c = 1; c <= 3 * 1140 + 50; c++) begin
      step();
      if (s_fs) begin
        if (last_fs < 0) begin
          check_eq("s_fs_first", c, 1);
        end else begin
          check_eq("s_frame_period", c - last_fs, 1140);
          check_eq("s_vis_strobes", don_cnt, S_HV * S_VV);
        end
        don_cnt = 0;
        last_fs = c;
        fs_seen++;
      end
      if (s_ce && s_don) don_cnt++;
      if (!s_vs) begin
        vs_run++;
      end else if (vs_run > 0) begin
        check_eq("s_vs_low_clk", vs_run, 180);
        vs_run = 0;
        vs_runs++;
      end
      if (int'(s_x) > max_x) max_x = int'(s_x);
      if (int'(s_y) > max_y) max_y = int'(s_y);
    end
    check_eq("s_fs_count", fs_seen, 4);
    check_eq("s_vs_pulses", vs_runs, 3);
    check_eq("s_max_x", max_x, 29);
    check_eq("s_max_y", max_y, 18);

    // Phase C: one-cycle reset at hc=22, vc=8 (inside hsync) on the small instance.
    do_reset(1);
    while (cyc < 524) step();
    check_eq("mid_pos", {s_x, s_y}, {10'd22, 10'd8});
    check_eq("mid_in_hsync", s_hs, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("mid_rst_hs", s_hs, 1);
    check_eq("mid_rst_xy", {s_x, s_y, d_x, d_y}, 0);
    check_eq("mid_rst_ce_fs", {s_ce, s_fs}, 2'b00);
    step();
    check_eq("mid_rel_fs", {s_fs, d_fs}, 2'b11);

    // Phase D: random run lengths between random-length resets.
    for (int it = 0; it < 16; it++) begin
      do_reset(int'($urandom_range(1, 3)));
      repeat (int'($urandom_range(1, 4000))) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
